// File: rtl/pes_pipeline_mul.sv
// Three-stage IEEE-754 binary32 multiplier: unpack/multiply, normalize, round/pack.
// Denormal operands and results flush to signed zero; NaN results are canonical.
module pes_pipeline_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] F
);

  // ---------------- stage 1: unpack / multiply ----------------
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [23:0] a_sig, b_sig;

  logic               sign1_d, sign1_q;
  logic signed [9:0]  exp1_d, exp1_q;
  logic [47:0]        prod1_d, prod1_q;
  logic               nan1_d, nan1_q, inf1_d, inf1_q, zero1_d, zero1_q;

  always_comb begin
    a_exp  = A[30:23];
    b_exp  = B[30:23];
    a_frac = A[22:0];
    b_frac = B[22:0];
    // exponent 0 covers both true zero and denormals, which are flushed
    a_zero = (a_exp == 8'h00);
    b_zero = (b_exp == 8'h00);
    a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
    b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
    a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
    b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);
    a_sig  = a_zero ? 24'd0 : {1'b1, a_frac};
    b_sig  = b_zero ? 24'd0 : {1'b1, b_frac};

    sign1_d = A[31] ^ B[31];
    exp1_d  = $signed({2'b00, a_exp} + {2'b00, b_exp} - 10'd127);
    prod1_d = a_sig * b_sig;
    nan1_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    inf1_d  = !nan1_d && (a_inf || b_inf);
    zero1_d = !nan1_d && !inf1_d && (a_zero || b_zero);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign1_q <= 1'b0;
      exp1_q  <= '0;
      prod1_q <= '0;
      nan1_q  <= 1'b0;
      inf1_q  <= 1'b0;
      zero1_q <= 1'b0;
    end else begin
      sign1_q <= sign1_d;
      exp1_q  <= exp1_d;
      prod1_q <= prod1_d;
      nan1_q  <= nan1_d;
      inf1_q  <= inf1_d;
      zero1_q <= zero1_d;
    end
  end

  // ---------------- stage 2: normalize ----------------
  logic               sign2_d, sign2_q;
  logic signed [9:0]  exp2_d, exp2_q;
  logic [22:0]        mant2_d, mant2_q;
  logic               guard2_d, guard2_q, sticky2_d, sticky2_q;
  logic               nan2_q, inf2_q, zero2_q;

  always_comb begin
    sign2_d = sign1_q;
    if (prod1_q[47]) begin
      mant2_d   = prod1_q[46:24];
      guard2_d  = prod1_q[23];
      sticky2_d = |prod1_q[22:0];
      exp2_d    = exp1_q + 10'sd1;
    end else begin
      mant2_d   = prod1_q[45:23];
      guard2_d  = prod1_q[22];
      sticky2_d = |prod1_q[21:0];
      exp2_d    = exp1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign2_q   <= 1'b0;
      exp2_q    <= '0;
      mant2_q   <= '0;
      guard2_q  <= 1'b0;
      sticky2_q <= 1'b0;
      nan2_q    <= 1'b0;
      inf2_q    <= 1'b0;
      zero2_q   <= 1'b0;
    end else begin
      sign2_q   <= sign2_d;
      exp2_q    <= exp2_d;
      mant2_q   <= mant2_d;
      guard2_q  <= guard2_d;
      sticky2_q <= sticky2_d;
      nan2_q    <= nan1_q;
      inf2_q    <= inf1_q;
      zero2_q   <= zero1_q;
    end
  end

  // ---------------- stage 3: round / pack ----------------
  logic               round_inc;
  logic [23:0]        mant_rnd;
  logic signed [9:0]  exp_rnd;
  logic [31:0]        f_d, f_q;

  always_comb begin
    round_inc = guard2_q && (sticky2_q || mant2_q[0]);
    // carry-out leaves the low 23 bits at zero, which is the correct mantissa
    mant_rnd  = {1'b0, mant2_q} + {23'd0, round_inc};
    exp_rnd   = exp2_q + $signed({9'd0, mant_rnd[23]});
    if (nan2_q) begin
      f_d = 32'h7FC0_0000;
    end else if (inf2_q) begin
      f_d = {sign2_q, 8'hFF, 23'd0};
    end else if (zero2_q) begin
      f_d = {sign2_q, 31'd0};
    end else if (exp_rnd >= 10'sd255) begin
      f_d = {sign2_q, 8'hFF, 23'd0};
    end else if (exp_rnd <= 10'sd0) begin
      f_d = {sign2_q, 31'd0};
    end else begin
      f_d = {sign2_q, exp_rnd[7:0], mant_rnd[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= '0;
    end else begin
      f_q <= f_d;
    end
  end

  assign F = f_q;

endmodule

// File: tb/tb_pes_pipeline_mul.sv
// Directed self-checking bench for pes_pipeline_mul; operands are driven on the
// falling edge and F is sampled on the falling edge, three rising edges later.
module tb_pes_pipeline_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A   = 32'h0;
  logic [31:0] B   = 32'h0;
  logic [31:0] F;

  int total = 0;
  int bad   = 0;

  pes_pipeline_mul dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .F   (F)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [31:0] ra[5] = '{32'h0000_0000, 32'h0000_0010, 32'h0000_00F0, 32'h0000_C000, 32'h4040_0000};
    logic [31:0] rb[5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0040, 32'h0000_1000, 32'h4000_0000};
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      A = ra[i % 5];
      B = rb[i % 5];
      total++;
      if (F !== 32'h0) begin
        bad++;
        $display("FAIL reset_held cycle %0d: F=%08h expected=%08h", i, F, 32'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    A = 32'h0;
    B = 32'h0;
    repeat (3) @(negedge clk);
    $display("reset_held: 20 cycles checked, F after release=%08h", F);
  endtask

  task automatic test_basic_latency();
    logic [31:0] va[3] = '{32'h3F80_0000, 32'h3FC0_0000, 32'hC000_0000};
    logic [31:0] vb[3] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    logic [31:0] vf[3] = '{32'h3F80_0000, 32'h4040_0000, 32'hC0C0_0000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A = va[i];
      B = vb[i];
      @(negedge clk);
      A = 32'h0;
      B = 32'h0;
      @(negedge clk);
      total++;
      if (F !== 32'h0) begin
        bad++;
        $display("FAIL latency_early %0d: F=%08h expected=%08h after 2 edges", i, F, 32'h0);
      end
      @(negedge clk);
      total++;
      if (F !== vf[i]) begin
        bad++;
        $display("FAIL basic %0d: %08h x %08h F=%08h expected=%08h", i, va[i], vb[i], F, vf[i]);
      end
      $display("basic: %08h x %08h -> F=%08h", va[i], vb[i], F);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[3] = '{32'h3F80_0000, 32'h3FC0_0000, 32'hC000_0000};
    logic [31:0] vb[3] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    logic [31:0] vf[3] = '{32'h3F80_0000, 32'h4040_0000, 32'hC0C0_0000};
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        total++;
        if (F !== vf[j-3]) begin
          bad++;
          $display("FAIL back_to_back %0d: F=%08h expected=%08h", j - 3, F, vf[j-3]);
        end
        $display("back_to_back: result %0d F=%08h", j - 3, F);
      end
      A = (j < 3) ? va[j] : 32'h0;
      B = (j < 3) ? vb[j] : 32'h0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_flush_round_overflow();
    logic [31:0] va[5] = '{32'h0000_AA00, 32'h8000_9000, 32'h0080_0000, 32'h3F80_0001, 32'h7F7F_FFFF};
    logic [31:0] vb[5] = '{32'h0000_0100, 32'h0000_8000, 32'h0080_0000, 32'h3F80_0001, 32'h4000_0000};
    logic [31:0] vf[5] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h3F80_0002, 32'h7F80_0000};
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        total++;
        if (F !== vf[j-3]) begin
          bad++;
          $display("FAIL flush_round_ovf %0d: %08h x %08h F=%08h expected=%08h",
                   j - 3, va[j-3], vb[j-3], F, vf[j-3]);
        end
        $display("flush_round_ovf: %08h x %08h -> F=%08h", va[j-3], vb[j-3], F);
      end
      A = (j < 5) ? va[j] : 32'h0;
      B = (j < 5) ? vb[j] : 32'h0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_specials();
    logic [31:0] va[6] = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h7F80_0000, 32'h8000_0000};
    logic [31:0] vb[6] = '{32'h0000_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h0000_1234, 32'h40A0_0000};
    logic [31:0] vf[6] = '{32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0000};
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        total++;
        if (F !== vf[j-3]) begin
          bad++;
          $display("FAIL specials %0d: %08h x %08h F=%08h expected=%08h",
                   j - 3, va[j-3], vb[j-3], F, vf[j-3]);
        end
        $display("specials: %08h x %08h -> F=%08h", va[j-3], vb[j-3], F);
      end
      A = (j < 6) ? va[j] : 32'h0;
      B = (j < 6) ? vb[j] : 32'h0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    logic [31:0] va[3] = '{32'h3F80_0000, 32'h3FC0_0000, 32'hC000_0000};
    logic [31:0] vb[3] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      A = va[j];
      B = vb[j];
    end
    @(negedge clk);
    total++;
    if (F !== 32'h3F80_0000) begin
      bad++;
      $display("FAIL midreset_pre: F=%08h expected=%08h", F, 32'h3F80_0000);
    end
    rst = 1'b1;
    A = 32'h0;
    B = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (F !== 32'h0) begin
        bad++;
        $display("FAIL midreset_flush %0d: F=%08h expected=%08h", k, F, 32'h0);
      end
      $display("midreset: cycle %0d F=%08h", k, F);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_back_to_back();
    test_flush_round_overflow();
    test_specials();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
